// File: rtl/bsg_manycore_pkg.sv
// ============================================================================
// Package : bsg_manycore_pkg
// Purpose : Shared types and helpers for the manycore link arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bsg_manycore_pkg;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eSend  = 2'd1,
    eFence = 2'd2
  } bsg_link_arb_state_e;

  localparam string bsg_link_arb_trace_prefix_lp = "[BSG_INFO][LINK_ARB]";

  // A width of at least one bit, even for single-valued quantities.
  function automatic int bsg_safe_clog2(input int val);
    return (val <= 1) ? 1 : $clog2(val);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_manycore_link_arb_rr_pick.sv
// ============================================================================
// Module  : bsg_manycore_link_arb_rr_pick
// Purpose : Combinational round-robin picker: first set request at or above
//           the pointer, wrapping from the top index back to 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_manycore_link_arb_rr_pick #(
  parameter int num_req_p  = 2,
  parameter int id_width_p = 1
) (
  input  logic [num_req_p-1:0]  req_i,
  input  logic [id_width_p-1:0] ptr_i,
  output logic [num_req_p-1:0]  grant_o,
  output logic [id_width_p-1:0] idx_o,
  output logic                  found_o
);

  // Scanning from the farthest offset down leaves the closest hit in place.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int off = num_req_p - 1; off >= 0; off--) begin
      int idx;
      idx = int'(ptr_i) + off;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        idx_o        = id_width_p'(idx);
        found_o      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_manycore_link_arbiter.sv
// ============================================================================
// Module  : bsg_manycore_link_arbiter
// Purpose : Shares one manycore injection port between num_req_p sources with
//           round-robin grants, credit gating and serialised fence draining.
//           Optional trace output: BSG_MANYCORE_LINK_ARBITER_TRACE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_manycore_link_arbiter
  import bsg_manycore_pkg::*;
#(
  parameter int   num_req_p               = 2,
  parameter int   packet_width_p          = 64,
  parameter int   max_out_credits_p       = 200,
  localparam int  credit_counter_width_lp = bsg_safe_clog2(max_out_credits_p + 1),
  localparam int  req_id_width_lp         = bsg_safe_clog2(num_req_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_packet_i,
  input  logic [num_req_p-1:0]                req_fence_i,
  output logic [num_req_p-1:0]                req_ready_o,
  output logic [num_req_p-1:0]                fence_done_o,
  output logic [packet_width_p-1:0]           packet_o,
  output logic                                v_o,
  input  logic                                ready_i,
  input  logic [credit_counter_width_lp-1:0]  out_credits_i,
  output logic [req_id_width_lp-1:0]          grant_id_o,
  output logic                                busy_o
);

  bsg_link_arb_state_e          state_q, state_d;
  logic [req_id_width_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [req_id_width_lp-1:0]   fence_id_q, fence_id_d;

  logic [num_req_p-1:0]         elig;
  logic [num_req_p-1:0]         win_oh, fence_oh;
  logic [req_id_width_lp-1:0]   win_idx, fence_idx;
  logic                         win_found, fence_found;
  logic                         hs;

  assign elig = req_v_i & ~req_fence_i;

  bsg_manycore_link_arb_rr_pick #(
    .num_req_p  (num_req_p),
    .id_width_p (req_id_width_lp)
  ) win_pick (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (win_oh),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  bsg_manycore_link_arb_rr_pick #(
    .num_req_p  (num_req_p),
    .id_width_p (req_id_width_lp)
  ) fence_pick (
    .req_i   (req_fence_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (fence_oh),
    .idx_o   (fence_idx),
    .found_o (fence_found)
  );

  always_comb begin
    packet_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (win_idx == req_id_width_lp'(i)) packet_o = req_packet_i[i*packet_width_p +: packet_width_p];
    end
  end

  // Outputs are forced low while reset is held so the port is quiet at once.
  always_comb begin
    v_o          = 1'b0;
    req_ready_o  = '0;
    fence_done_o = '0;
    grant_id_o   = '0;
    hs           = 1'b0;
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    fence_id_d   = fence_id_q;
    if (!reset_i) begin
      case (state_q)
        eFence: begin
          if (!req_fence_i[fence_id_q]) begin
            state_d = eIdle;
          end else if (out_credits_i == credit_counter_width_lp'(max_out_credits_p)) begin
            fence_done_o[fence_id_q] = 1'b1;
            state_d                  = eIdle;
          end
        end
        default: begin
          if ((out_credits_i != '0) && win_found) begin
            v_o         = 1'b1;
            grant_id_o  = win_idx;
            req_ready_o = win_oh & {num_req_p{ready_i}};
          end
          hs = v_o & ready_i;
          if (hs) begin
            rr_ptr_d = (win_idx == req_id_width_lp'(num_req_p - 1)) ? '0 : win_idx + 1'b1;
          end
          // An accepted packet must be counted before the drain check starts.
          if (fence_found && !hs) begin
            state_d    = eFence;
            fence_id_d = fence_idx;
          end else begin
            state_d = win_found ? eSend : eIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= eIdle;
      rr_ptr_q   <= '0;
      fence_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      fence_id_q <= fence_id_d;
    end
  end

  assign busy_o = (state_q != eIdle);

`ifdef BSG_MANYCORE_LINK_ARBITER_TRACE_EN
  logic [31:0] fence_cycles_q, fence_cycles_d;

  always_comb begin
    fence_cycles_d = '0;
    if (state_q == eFence) fence_cycles_d = fence_cycles_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) fence_cycles_q <= '0;
    else         fence_cycles_q <= fence_cycles_d;
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (v_o && ready_i)
        $display("%s req=%0d addr/data=%h t=%0t", bsg_link_arb_trace_prefix_lp, grant_id_o, packet_o, $time);
      if (|fence_done_o)
        $display("%s fence_done req=%0d cycles=%0d t=%0t", bsg_link_arb_trace_prefix_lp, fence_id_q,
                 fence_cycles_q + 32'd1, $time);
    end
  end
`else
  // Default build carries no trace state.
`endif

`ifndef SYNTHESIS
  always @(negedge clk_i) begin
    if (!reset_i) begin
      assert (out_credits_i <= credit_counter_width_lp'(max_out_credits_p))
        else $error("link_arb: out_credits_i %0d exceeds max %0d", out_credits_i, max_out_credits_p);
      assert ($onehot0(win_oh) && $onehot0(fence_oh))
        else $error("link_arb: picker grant not one-hot");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_link_arbiter.sv
// ============================================================================
// Module  : tb_bsg_manycore_link_arbiter
// Purpose : Scoreboard bench: directed scenarios plus random traffic checked
//           against an abstract per-cycle arbitration model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bsg_manycore_link_arbiter;

  localparam int NR   = 2;
  localparam int PW   = 16;
  localparam int MAXC = 200;

  logic          clk;
  logic          reset_i;
  logic [NR-1:0] req_v_i, req_fence_i, req_ready_o, fence_done_o;
  logic [NR*PW-1:0] req_packet_i;
  logic [PW-1:0] packet_o;
  logic          v_o, ready_i, busy_o;
  logic [7:0]    out_credits_i;
  logic [0:0]    grant_id_o;

  bsg_manycore_link_arbiter #(
    .num_req_p         (NR),
    .packet_width_p    (PW),
    .max_out_credits_p (MAXC)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_v_i       (req_v_i),
    .req_packet_i  (req_packet_i),
    .req_fence_i   (req_fence_i),
    .req_ready_o   (req_ready_o),
    .fence_done_o  (fence_done_o),
    .packet_o      (packet_o),
    .v_o           (v_o),
    .ready_i       (ready_i),
    .out_credits_i (out_credits_i),
    .grant_id_o    (grant_id_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [0:0]    gid;
    logic [NR-1:0] rdy;
    logic [NR-1:0] fd;
    logic          busy;
    logic [PW-1:0] pkt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus state
  logic [NR-1:0] s_v = '0, s_f = '0, last_fd = '0;
  logic          s_rdy = 1'b0;
  logic [7:0]    s_cr = 8'd200;
  logic [PW-1:0] s_pkt [NR];

  // Reference model state
  int m_ptr     = 0;
  bit m_fencing = 0;
  int m_fsrc    = 0;
  bit m_busy    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int rot_first(input logic [NR-1:0] vec, input int start);
    for (int off = 0; off < NR; off++) begin
      int idx;
      idx = (start + off) % NR;
      if (vec[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    exp_t e;
    int w, f;
    logic [NR-1:0] elig;
    bit hs;
    @(posedge clk); #1;
    s_f = s_f & ~last_fd;
    req_v_i       = s_v;
    req_fence_i   = s_f;
    ready_i       = s_rdy;
    out_credits_i = s_cr;
    req_packet_i  = {s_pkt[1], s_pkt[0]};
    e.v = 0; e.gid = '0; e.rdy = '0; e.fd = '0; e.pkt = '0;
    e.busy = m_busy;
    if (m_fencing) begin
      if (!s_f[m_fsrc]) m_fencing = 0;
      else if (s_cr == MAXC) begin
        e.fd[m_fsrc] = 1'b1;
        m_fencing    = 0;
      end
      m_busy = m_fencing;
    end else begin
      elig = s_v & ~s_f;
      w = rot_first(elig, m_ptr);
      f = rot_first(s_f, m_ptr);
      if (s_cr != 0 && w >= 0) begin
        e.v = 1; e.gid = w[0:0]; e.pkt = s_pkt[w]; e.rdy[w] = s_rdy;
      end
      hs = e.v && s_rdy;
      if (hs) m_ptr = (w + 1) % NR;
      if (f >= 0 && !hs) begin
        m_fencing = 1;
        m_fsrc    = f;
      end
      m_busy = m_fencing || (elig != 0);
    end
    last_fd = e.fd;
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("v_o", 64'(v_o), 64'(mon_e.v));
        chk("grant_id_o", 64'(grant_id_o), 64'(mon_e.gid));
        chk("req_ready_o", 64'(req_ready_o), 64'(mon_e.rdy));
        chk("fence_done_o", 64'(fence_done_o), 64'(mon_e.fd));
        chk("busy_o", 64'(busy_o), 64'(mon_e.busy));
        if (mon_e.v) chk("packet_o", 64'(packet_o), 64'(mon_e.pkt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; req_v_i = 2'b11; req_fence_i = '0; ready_i = 1'b1;
    out_credits_i = 8'd200; req_packet_i = 32'h1234_5678;
    s_pkt[0] = 16'hA000; s_pkt[1] = 16'hB001;
    #2;
    chk("reset_v_o", 64'(v_o), 64'd0);
    chk("reset_req_ready_o", 64'(req_ready_o), 64'd0);
    chk("reset_fence_done_o", 64'(fence_done_o), 64'd0);
    chk("reset_busy_o", 64'(busy_o), 64'd0);
    chk("reset_grant_id_o", 64'(grant_id_o), 64'd0);
    req_v_i = '0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    // Alternating grants, then a lone source 1 and a stalled network
    s_cr = 8'd200; s_rdy = 1'b1; s_v = 2'b11;
    repeat (4) step();
    s_v = 2'b10; step();
    s_v = 2'b11; s_rdy = 1'b0; repeat (3) step();
    s_rdy = 1'b1; step();

    // Credit gating
    s_cr = 8'd0; repeat (2) step();
    s_cr = 8'd5; step();

    // Single fence waiting for the drain
    s_v = 2'b00; s_f = 2'b01; s_cr = 8'd190; step();
    s_v = 2'b10; repeat (3) step();
    s_cr = 8'd200; repeat (3) step();

    // Two simultaneous fences served one after the other
    s_v = 2'b00; s_f = 2'b11; s_cr = 8'd200;
    repeat (6) step();

    // Asynchronous reset in the middle of a fence
    s_f = 2'b00; s_v = 2'b01; s_cr = 8'd190; step();
    s_v = 2'b00; s_f = 2'b10; step(); step();
    @(negedge clk); #1;
    s_v = 2'b11; s_f = 2'b00; req_v_i = 2'b11; req_fence_i = 2'b00;
    #1 reset_i = 1'b1;
    #1;
    chk("midfence_reset_v_o", 64'(v_o), 64'd0);
    chk("midfence_reset_fence_done_o", 64'(fence_done_o), 64'd0);
    chk("midfence_reset_busy_o", 64'(busy_o), 64'd0);
    chk("midfence_reset_req_ready_o", 64'(req_ready_o), 64'd0);
    req_v_i = 2'b00;
    @(posedge clk); #1 reset_i = 1'b0;
    m_ptr = 0; m_fencing = 0; m_busy = 0; last_fd = '0;
    s_cr = 8'd200; s_rdy = 1'b1; s_v = 2'b11; step();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      s_v   = NR'($urandom);
      s_rdy = ($urandom % 4) != 0;
      r = $urandom % 10;
      if (r == 0)      s_cr = 8'd0;
      else if (r < 5)  s_cr = 8'd200;
      else             s_cr = 8'($urandom_range(1, 200));
      s_pkt[0] = PW'($urandom);
      s_pkt[1] = PW'($urandom);
      if (s_f == '0 && ($urandom % 12) == 0) s_f = NR'($urandom_range(1, 3));
      else if (s_f != '0 && ($urandom % 40) == 0) s_f = '0;
      step();
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsg_manycore_link_arbiter.md
Name: bsg_manycore_link_arbiter

Overview:
- Shares one manycore network injection port (packet/v/ready plus out_credits) between num_req_p packet sources, for example the SPMD loader, a host bridge and a DMA trace player.
- Round-robin arbitration between sources on each handshake.
- Stops injection when no credits remain.
- Serialises per-source fence requests: all traffic halts until every outstanding credit has returned.
- Sits between the sources and the endpoint's out-packet link in the testbench top.

Parameters:
- num_req_p, 2, number of requesting sources (1..8).
- packet_width_p, "inv", manycore packet width from the packet-width macro.
- max_out_credits_p, 200, credit count at which the network is drained.
- credit_counter_width_lp, BSG_SAFE_CLOG2(max_out_credits_p+1), width of out_credits_i (derived).
- req_id_width_lp, BSG_SAFE_CLOG2(num_req_p), width of grant_id_o (derived).

Ports:
- clk_i, input, 1, clock; all state updates on posedge.
- reset_i, input, 1, asynchronous active-high reset.
- req_v_i, input, num_req_p, per-source packet valid.
- req_packet_i, input, num_req_p*packet_width_p, per-source packets; source i is at slice [i*packet_width_p +: packet_width_p].
- req_fence_i, input, num_req_p, per-source fence request; level, held until fence_done_o.
- req_ready_o, output, num_req_p, per-source ready; one-hot or zero.
- fence_done_o, output, num_req_p, one-cycle pulse to the fencing source.
- packet_o, output, packet_width_p, the granted packet.
- v_o, output, 1, valid to the network.
- ready_i, input, 1, network ready.
- out_credits_i, input, credit_counter_width_lp, available credits.
- grant_id_o, output, req_id_width_lp, index of the current winner; 0 when v_o=0.
- busy_o, output, 1, high while state is not eIdle.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=eIdle, rr_ptr_r=0, fence_id_r=0.
  - All outputs 0; packet_o is don't-care (driven by mux, value unchecked).
- States are eIdle, eSend and eFence.
- Eligible set E = req_v_i & ~req_fence_i. A source asserting fence is never granted for a packet.
- Winner = first index in E scanning upward from rr_ptr_r and wrapping at num_req_p-1 to 0.
- eIdle / eSend, combinational per cycle:
  - If out_credits_i==0: v_o=0, req_ready_o=0.
  - Else if E!=0: v_o=1, packet_o=winner's packet, grant_id_o=winner, req_ready_o[winner]=ready_i.
  - State is eSend while E!=0, eIdle otherwise (busy_o reflects this).
- On handshake (v_o & ready_i): rr_ptr_r <= (winner==num_req_p-1) ? 0 : winner+1. Without a handshake, rr_ptr_r holds.
- Grant is not sticky: the winner is recomputed every cycle. A source dropping v before the handshake loses its slot with no penalty.
- Fence entry:
  - In eIdle/eSend, when any req_fence_i is high and no handshake occurs this cycle, go to eFence.
  - fence_id_r <= first fencing index scanned from rr_ptr_r, wrapping.
  - If a handshake does occur that cycle, fence entry is deferred one cycle, so an accepted packet is always counted before the drain check.
- eFence:
  - v_o=0, req_ready_o=0.
  - Wait while out_credits_i != max_out_credits_p.
  - On equality: pulse fence_done_o[fence_id_r] for exactly one cycle and return to eIdle. The source must drop req_fence_i in the cycle after the pulse.
  - If req_fence_i[fence_id_r] is withdrawn early: return to eIdle with no pulse.
  - Latency when already drained: fence_done_o appears 1 cycle after entry (entry cycle, then pulse cycle).
- Simultaneous fences are served one at a time in round-robin order; rr_ptr_r does not advance on fences.
- Reset mid-fence or mid-send: state is abandoned, no fence_done_o pulse, pointer returns to 0.
- Bounds:
  - out_credits_i > max_out_credits_p is illegal; flagged by an assertion under a nonsynth guard.
  - num_req_p==1 makes the pointer a constant 0.

Optional Feature:
- Macro BSG_MANYCORE_LINK_ARBITER_TRACE_EN.
- When defined:
  - On negedge clk_i, outside reset, each handshake prints "[BSG_INFO][LINK_ARB] req=%0d addr/data" with $time.
  - Each fence_done pulse prints its source id and the number of cycles spent in eFence, using a 32-bit cycle counter that exists only under the macro.
- When undefined: no counter, no display, identical port behaviour.

Decomposition:
- Shared package bsg_manycore_pkg holds:
  - typedef enum logic [1:0] {eIdle, eSend, eFence} bsg_link_arb_state_e.
  - The trace prefix string constant.
- One sub-module, bsg_manycore_link_arb_rr_pick: a purely combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, found flag.
  - Instantiated twice: once for packet winner, once for fence selection.

Test Plan:
- Both sources hold v with ready_i=1 and credits=200: grants alternate 0,1,0,1 across 4 cycles, and each packet_o equals the granted source's packet.
- Only source 1 valid with rr_ptr_r=0: grant_id_o=1 and rr_ptr_r becomes 0 after the handshake. With ready_i=0 for 3 cycles, v_o stays 1, packet_o is stable and the pointer does not move.
- out_credits_i=0 with both sources valid: v_o=0 and req_ready_o=0. Raise credits to 5: v_o=1 in the same cycle.
- Source 0 fences with credits=190: busy_o=1, v_o=0. Source 1 is blocked until credits reach 200, then fence_done_o[0] pulses for exactly 1 cycle and the state returns to eIdle.
- Both sources fence together, credits=200: fence_done_o[0] pulses at cycle 2 and fence_done_o[1] at cycle 4, with no v_o in between.
- Assert reset_i asynchronously mid-eFence: outputs are 0 immediately, no fence_done_o pulse, and the first grant after release goes to source 0.
